fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of instruction_mem in the Single_Cycle_Datapath.
- Owns the program counter and drives pc into instruction_mem, which returns instr combinationally in the same cycle.
- Registers {pc, instr} into an IF/ID output register with a valid/ready handshake toward decode.
- Accepts branch/jal redirects and traps misaligned or out-of-range fetch addresses.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- IMEM_BYTES, 65536, instruction memory size in bytes; a fetch at pc with pc+3 >= IMEM_BYTES is out of range.
- BOOT_CYCLES, 2, idle cycles after reset before the first fetch (allows memory initial load). Must be >= 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pc  out  64  fetch address to instruction_mem; equals pc_q.
- imem_instr  in  32  instruction word from instruction_mem for the current pc.
- redirect_valid  in  1  branch-taken/jal; loads redirect_target this cycle.
- redirect_target  in  64  new PC.
- out_valid  out  1  IF/ID entry holds a valid instruction.
- out_ready  in  1  decode accepts the entry this cycle.
- out_pc  out  64  PC of the held instruction.
- out_instr  out  32  held instruction word.
- out_pc_plus4  out  64  out_pc + 4, modulo 2^64 (combinational from out_pc).
- fault  out  1  sticky fetch fault.
- fault_addr  out  64  address that caused the fault.
- fetch_count  out  32  number of instructions captured into IF/ID; wraps at 2^32.

Behaviour:
- Reset values: pc_q=RESET_PC, state=BOOT, boot counter=0, out_valid=0, out_pc=0, out_instr=0, fault=0, fault_addr=0, fetch_count=0.
- rst has priority over every other input.

States:
- BOOT:
  - Counter increments each cycle; out_valid stays 0.
  - After BOOT_CYCLES cycles, transition to RUN.
  - A redirect in BOOT updates pc_q (alignment and range checks apply); BOOT length is unchanged.
- RUN, in priority order:
  1. redirect_valid=1:
     - out_valid <= 0, flushing the held entry even if out_valid=1 and out_ready=0.
     - If redirect_target[1:0] != 0 or redirect_target+3 >= IMEM_BYTES: enter FAULT; fault <= 1; fault_addr <= redirect_target; pc_q unchanged.
     - Otherwise: pc_q <= redirect_target.
     - No capture occurs in a redirect cycle.
  2. out_valid=0 or out_ready=1 (slot free or draining):
     - If pc_q+3 >= IMEM_BYTES: enter FAULT; fault_addr <= pc_q; out_valid <= 0.
     - Otherwise capture: out_pc <= pc_q; out_instr <= imem_instr; out_valid <= 1; pc_q <= pc_q+4; fetch_count += 1.
  3. out_valid=1 and out_ready=0 (stall): hold pc_q and all out_* registers unchanged.
- FAULT:
  - Terminal until rst.
  - out_valid=0; pc_q frozen; redirects ignored; fetch_count frozen.

Timing and throughput:
- Latency: the instruction at pc_q appears on out_* one cycle after capture.
- Throughput: 1 instruction/cycle while out_ready=1.

Arithmetic and boundaries:
- PC arithmetic is 64-bit unsigned and wraps mod 2^64.
- The range check uses a 65-bit sum so that wrap-around cannot mask an overflow.
- The out_ready value is irrelevant while out_valid=0.

Decomposition:
- Shared package riscv_fetch_pkg:
  - fetch state enum {BOOT, RUN, FAULT}, 2-bit.
  - INSTR_BYTES=4.
  - NOP encoding 32'h00000013.
  - XLEN=64.
- One natural sub-module, fetch_pc_reg: PC register with redirect/increment mux and the alignment/range check, emitting fault_req.
- The FSM, IF/ID register and counter stay in fetch_unit.

Test Plan:
1. Reset, then BOOT_CYCLES=2, out_ready=1 → out_valid first rises on cycle 3. out_pc sequence 0,4,8. out_instr at pc 0 = 32'h015A04B3 and at pc 4 = 32'h00148493. fetch_count=3 after 3 captures.
2. Backpressure: out_ready=0 for 3 cycles while out_valid=1 at out_pc=8 → out_pc/out_instr stable, pc_q stays 12, fetch_count unchanged. On release, the next capture is out_pc=12.
3. Redirect to 64'h12C while out_valid=1 and out_ready=0 → next cycle out_valid=0. The following cycle out_pc=12C, out_instr=32'h0500006F.
4. Redirect to 64'h32 (misaligned) → fault=1, fault_addr=64'h32, out_valid=0 thereafter. A later redirect to 64'h0 is ignored. rst clears fault and restarts at RESET_PC.
5. RESET_PC=64'hFFFC with IMEM_BYTES=65536 → the FFFC fetch is accepted. The next fetch at 64'h10000 raises fault with fault_addr=64'h10000.
6. rst asserted mid-stream together with redirect_valid=1 → all outputs return to reset values, pc=RESET_PC, and the redirect has no effect.

Source files
------------

// File: rtl/riscv_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, fetch FSM states
// and the fetch-address range check.
package riscv_fetch_pkg;

  localparam int unsigned XLEN        = 64;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP         = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  // 65-bit sum so an address near 2^64 cannot wrap back into range.
  function automatic logic addr_oor(input logic [XLEN-1:0] addr,
                                    input longint unsigned mem_bytes);
    return ({1'b0, addr} + 65'(INSTR_BYTES - 1)) >= 65'(mem_bytes);
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with redirect/increment selection and the alignment/range
// checks that decide whether a redirect or a fetch must trap.
module fetch_pc_reg
  import riscv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter longint unsigned IMEM_BYTES = 65536
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] target_i,
  input  logic            fetch_i,
  output logic [XLEN-1:0] pc_o,
  output logic            capture_o,
  output logic            fault_req_o,
  output logic [XLEN-1:0] fault_addr_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            target_bad;
  logic            pc_oor;

  always_comb begin
    target_bad   = (target_i[1:0] != 2'b00) || addr_oor(target_i, IMEM_BYTES);
    pc_oor       = addr_oor(pc_q, IMEM_BYTES);
    capture_o    = fetch_i && !pc_oor;
    fault_req_o  = (redirect_i && target_bad) || (fetch_i && pc_oor);
    fault_addr_o = redirect_i ? target_i : pc_q;
    pc_d         = pc_q;
    if (redirect_i) begin
      if (!target_bad) pc_d = target_i;
    end else if (capture_o) begin
      pc_d = pc_q + XLEN'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: boot delay, PC sequencing, IF/ID output register
// with valid/ready handshake, and sticky trap on bad fetch addresses.
module fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [63:0]     RESET_PC    = 64'h0,
  parameter longint unsigned IMEM_BYTES  = 65536,
  parameter int unsigned     BOOT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc_plus4,
  output logic        fault,
  output logic [63:0] fault_addr,
  output logic [31:0] fetch_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  boot_cnt_q, boot_cnt_d;
  logic         out_valid_q, out_valid_d;
  logic [63:0]  out_pc_q, out_pc_d;
  logic [31:0]  out_instr_q, out_instr_d;
  logic         fault_q, fault_d;
  logic [63:0]  fault_addr_q, fault_addr_d;
  logic [31:0]  fetch_count_q, fetch_count_d;

  logic         redir, fetch_req, capture, fault_req;
  logic [63:0]  fault_addr_req;

  // Redirects are honoured in BOOT and RUN; a fetch is only attempted in RUN
  // when the slot is free or draining and no redirect is pending.
  assign redir     = redirect_valid && (state_q != FAULT);
  assign fetch_req = (state_q == RUN) && !redirect_valid && (!out_valid_q || out_ready);

  fetch_pc_reg #(
    .RESET_PC   (RESET_PC),
    .IMEM_BYTES (IMEM_BYTES)
  ) u_pc (
    .clk          (clk),
    .rst          (rst),
    .redirect_i   (redir),
    .target_i     (redirect_target),
    .fetch_i      (fetch_req),
    .pc_o         (pc),
    .capture_o    (capture),
    .fault_req_o  (fault_req),
    .fault_addr_o (fault_addr_req)
  );

  always_comb begin
    state_d       = state_q;
    boot_cnt_d    = boot_cnt_q;
    out_valid_d   = out_valid_q;
    out_pc_d      = out_pc_q;
    out_instr_d   = out_instr_q;
    fault_d       = fault_q;
    fault_addr_d  = fault_addr_q;
    fetch_count_d = fetch_count_q;
    unique case (state_q)
      BOOT: begin
        boot_cnt_d = boot_cnt_q + 32'd1;
        if (boot_cnt_q == 32'(BOOT_CYCLES - 1)) state_d = RUN;
      end
      RUN: begin
        if (redirect_valid) out_valid_d = 1'b0;
        else if (capture) begin
          out_valid_d   = 1'b1;
          out_pc_d      = pc;
          out_instr_d   = imem_instr;
          fetch_count_d = fetch_count_q + 32'd1;
        end
      end
      FAULT:   out_valid_d = 1'b0;
      default: state_d = FAULT;
    endcase
    if (fault_req) begin
      state_d      = FAULT;
      fault_d      = 1'b1;
      fault_addr_d = fault_addr_req;
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      boot_cnt_q    <= '0;
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      out_instr_q   <= '0;
      fault_q       <= 1'b0;
      fault_addr_q  <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      boot_cnt_q    <= boot_cnt_d;
      out_valid_q   <= out_valid_d;
      out_pc_q      <= out_pc_d;
      out_instr_q   <= out_instr_d;
      fault_q       <= fault_d;
      fault_addr_q  <= fault_addr_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = out_pc_q;
  assign out_instr    = out_instr_q;
  assign out_pc_plus4 = out_pc_q + 64'(INSTR_BYTES);
  assign fault        = fault_q;
  assign fault_addr   = fault_addr_q;
  assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios followed by random
// redirect/backpressure/reset traffic against a transaction-level model.
module tb_fetch_unit;

  localparam logic [63:0]     RESET_PC    = 64'h0;
  localparam longint unsigned IMEM_BYTES  = 65536;
  localparam int unsigned     BOOT_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [63:0] out_pc_plus4;
  logic        fault;
  logic [63:0] fault_addr;
  logic [31:0] fetch_count;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC    (RESET_PC),
    .IMEM_BYTES  (IMEM_BYTES),
    .BOOT_CYCLES (BOOT_CYCLES)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .imem_instr      (imem_instr),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instr       (out_instr),
    .out_pc_plus4    (out_pc_plus4),
    .fault           (fault),
    .fault_addr      (fault_addr),
    .fetch_count     (fetch_count)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h0:   return 32'h015A04B3;
      64'h4:   return 32'h00148493;
      64'h12C: return 32'h0500006F;
      default: return (a[31:0] * 32'h9E3779B1) ^ 32'h13;
    endcase
  endfunction

  assign imem_instr = mem_word(pc);

  typedef struct packed {
    logic        v;
    logic        f;
    logic [63:0] fa;
    logic [31:0] cnt;
    logic [63:0] pc;
  } status_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] pc4;
  } entry_t;

  status_t st_q[$];
  entry_t  ex_q[$];
  int      n_checks = 0;
  int      n_pass   = 0;
  bit      run_en   = 0;

  // Reference model state
  logic [63:0] m_pc, m_hpc, m_faddr;
  logic [31:0] m_hinstr, m_cnt;
  bit          m_held, m_faulted;
  int          m_boot_left;

  function automatic bit bad_addr(input logic [63:0] a);
    logic [64:0] top;
    top = {1'b0, a} + 65'd3;
    return (a % 4 != 0) || (top >= 65'(IMEM_BYTES));
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_hpc = '0; m_hinstr = '0; m_held = 0;
    m_faulted = 0; m_faddr = '0; m_cnt = '0; m_boot_left = BOOT_CYCLES;
  endtask

  task automatic raise(input logic [63:0] a);
    m_faulted = 1; m_faddr = a; m_held = 0;
  endtask

  task automatic model_step(input bit r, input bit rv, input logic [63:0] rt, input bit rdy);
    if (r) begin model_reset(); return; end
    if (m_faulted) return;
    if (m_boot_left > 0) begin
      m_boot_left--;
      if (rv) begin
        if (bad_addr(rt)) raise(rt); else m_pc = rt;
      end
      return;
    end
    if (rv) begin
      m_held = 0;
      if (bad_addr(rt)) raise(rt); else m_pc = rt;
      return;
    end
    if (m_held && !rdy) return;
    if (bad_addr(m_pc)) begin raise(m_pc); return; end
    m_held = 1; m_hpc = m_pc; m_hinstr = mem_word(m_pc);
    m_pc = m_pc + 64'd4; m_cnt = m_cnt + 32'd1;
  endtask

  // Drives one cycle of inputs, records what the DUT should show this cycle,
  // then advances the model across the coming clock edge.
  task automatic cyc(input bit r, input bit rv, input logic [63:0] rt, input bit rdy);
    rst = r; redirect_valid = rv; redirect_target = rt; out_ready = rdy;
    st_q.push_back('{v: m_held, f: m_faulted, fa: m_faddr, cnt: m_cnt, pc: m_pc});
    if (m_held && rdy) ex_q.push_back('{pc: m_hpc, instr: m_hinstr, pc4: m_hpc + 64'd4});
    model_step(r, rv, rt, rdy);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (run_en) begin
      status_t got, exp_s;
      entry_t  gote, expe;
      got = '{v: out_valid, f: fault, fa: fault_addr, cnt: fetch_count, pc: pc};
      n_checks++;
      if (st_q.size() == 0) begin
        $display("FAIL status_underflow got=%h", got);
      end else begin
        exp_s = st_q.pop_front();
        if (got === exp_s) n_pass++;
        else $display("FAIL status t=%0t got v=%b f=%b fa=%h cnt=%0d pc=%h exp v=%b f=%b fa=%h cnt=%0d pc=%h",
                      $time, got.v, got.f, got.fa, got.cnt, got.pc,
                      exp_s.v, exp_s.f, exp_s.fa, exp_s.cnt, exp_s.pc);
      end
      if (out_valid && out_ready) begin
        gote = '{pc: out_pc, instr: out_instr, pc4: out_pc_plus4};
        n_checks++;
        if (ex_q.size() == 0) begin
          $display("FAIL entry_unexpected got pc=%h instr=%h", out_pc, out_instr);
        end else begin
          expe = ex_q.pop_front();
          if (gote === expe) n_pass++;
          else $display("FAIL entry t=%0t got pc=%h instr=%h pc4=%h exp pc=%h instr=%h pc4=%h",
                        $time, gote.pc, gote.instr, gote.pc4, expe.pc, expe.instr, expe.pc4);
        end
      end
    end
  end

  initial begin
    logic [63:0] tgt;
    rst = 1'b1; redirect_valid = 1'b0; redirect_target = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    run_en = 1;

    // Boot then stream three instructions
    repeat (5) cyc(0, 0, 64'h0, 1);
    // Backpressure while holding pc 8
    repeat (3) cyc(0, 0, 64'h0, 0);
    cyc(0, 0, 64'h0, 1);
    cyc(0, 0, 64'h0, 0);
    // Redirect flushes a stalled entry
    cyc(0, 1, 64'h12C, 0);
    repeat (3) cyc(0, 0, 64'h0, 1);
    // Misaligned redirect traps; later redirect ignored
    cyc(0, 1, 64'h32, 1);
    repeat (2) cyc(0, 1, 64'h0, 1);
    repeat (2) cyc(0, 0, 64'h0, 1);
    // Reset, boot-time redirect to the top of memory, run off the end
    cyc(1, 0, 64'h0, 1);
    cyc(0, 1, 64'hFFF0, 1);
    repeat (7) cyc(0, 0, 64'h0, 1);
    // Reset together with a redirect mid-stream
    cyc(1, 0, 64'h0, 1);
    repeat (5) cyc(0, 0, 64'h0, 1);
    cyc(1, 1, 64'h40, 1);
    repeat (4) cyc(0, 0, 64'h0, 1);

    for (int i = 0; i < 3000; i++) begin
      bit r, rv, rdy;
      r   = m_faulted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 199) == 0);
      rv  = ($urandom_range(0, 15) == 0);
      rdy = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 5))
        0, 1, 2: tgt = {54'd0, 8'($urandom_range(0, 255)), 2'b00};
        3:       tgt = {54'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
        4:       tgt = 64'h10000 - 64'(4 * $urandom_range(1, 4));
        default: tgt = ($urandom_range(0, 1) == 1) ? 64'h10000 : 64'hFFFF_FFFF_FFFF_FFFC;
      endcase
      cyc(r, rv, tgt, rdy);
    end

    run_en = 0;
    n_checks++;
    if (st_q.size() == 0 && ex_q.size() == 0) n_pass++;
    else $display("FAIL drain got status=%0d entries=%0d exp 0 0", st_q.size(), ex_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
